// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch slice.
//   FETCH_ADDR_W / FETCH_DATA_W : default address and instruction widths
//   FETCH_RESET_PC              : default first fetch address after reset
//   INST_BYTES                  : byte stride between consecutive instructions
//   fetch_entry_t               : buffered instruction together with its PC
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] inst;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the instruction-memory handshake, the redirect
// input and the decode-side valid/ready channel of fetch_ctrl.
//   imem_req_o / imem_addr_o / imem_gnt_i        : request channel
//   imem_rvalid_i / imem_rdata_i                 : in-order response channel
//   redirect_i / redirect_pc_i                   : branch/jump redirect
//   inst_valid_o / inst_o / inst_pc_o / inst_ready_i : decode channel
// master = fetch_ctrl side, slave = memory/decode environment side.
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
);

    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               redirect_i, redirect_pc_i, inst_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/data_i: write request and data (ignored when full without pop)
//   pop_i        : read request, head advances when non-empty
//   flush_i      : empties the FIFO; overrides push and pop
//   data_o       : head entry (stale contents when empty)
//   count_o      : number of stored entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = logic [FETCH_ADDR_W-1:0],
    parameter int  DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output T                           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop, full;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        // A full FIFO still accepts a push when the head leaves this cycle.
        do_push  = push_i && !flush_i && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
//   clk_i : clock, all state on rising edge
//   rst_i : asynchronous active-high reset
//   bus   : fetch_ctrl_if.master
//           imem_req_o/imem_addr_o/imem_gnt_i      word-aligned fetch requests
//           imem_rvalid_i/imem_rdata_i             in-order responses
//           redirect_i/redirect_pc_i               branch redirect (highest priority)
//           inst_valid_o/inst_o/inst_pc_o/inst_ready_i  decode channel
// Owns the PC, limits in-flight plus buffered instructions to DEPTH, and
// discards responses that belong to fetches issued before a redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
    parameter int                DEPTH    = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_ctrl_if.master bus
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int USED_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              run_q;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [CNT_W-1:0]  pcq_cnt, instq_cnt, outstanding_d;
    logic [ADDR_W-1:0] pcq_head;
    fetch_entry_t      inst_push_data, inst_head;
    logic [USED_W-1:0] used;
    logic              inst_valid, inst_pop, req, req_fire, rsp_ok, rsp_keep;

    always_comb begin
        inst_valid = (instq_cnt != '0);
        inst_pop   = inst_valid && bus.inst_ready_i;
        // A slot handed to decode this cycle is already free for a new request,
        // which keeps one instruction per cycle flowing with DEPTH = 2.
        used       = USED_W'(pcq_cnt) + USED_W'(instq_cnt) - USED_W'(inst_pop);
        req        = run_q && !bus.redirect_i && (used < USED_W'(DEPTH));
        req_fire   = req && bus.imem_gnt_i;
        // Responses with nothing outstanding are protocol errors and ignored.
        rsp_ok     = bus.imem_rvalid_i && (pcq_cnt != '0);
        rsp_keep   = rsp_ok && (discard_q == '0);

        inst_push_data.inst = bus.imem_rdata_i;
        inst_push_data.pc   = pcq_head;

        outstanding_d = pcq_cnt + CNT_W'(req_fire) - CNT_W'(rsp_ok);

        pc_d      = pc_q;
        discard_d = discard_q;
        if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
        if (req_fire) pc_d = pc_q + ADDR_W'(INST_BYTES);
        if (bus.redirect_i) begin
            pc_d      = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
            // Everything still in flight after this cycle predates the redirect.
            discard_d = outstanding_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            run_q     <= 1'b0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            run_q     <= 1'b1;
            discard_q <= discard_d;
        end
    end

    // PCs of issued requests, matched to responses in order.
    fetch_fifo #(
        .T     (logic [ADDR_W-1:0]),
        .DEPTH (DEPTH)
    ) u_pcq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (rsp_ok),
        .flush_i (1'b0),
        .data_o  (pcq_head),
        .count_o (pcq_cnt)
    );

    // Returned instructions waiting for decode; a redirect drops them all,
    // including a response arriving in the redirect cycle.
    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_instq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rsp_keep),
        .data_i  (inst_push_data),
        .pop_i   (inst_pop),
        .flush_i (bus.redirect_i),
        .data_o  (inst_head),
        .count_o (instq_cnt)
    );

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = pc_q;
    assign bus.inst_valid_o = inst_valid;
    assign bus.inst_o       = inst_head.inst;
    assign bus.inst_pc_o    = inst_head.pc;

    a_rvalid_has_request: assert property (
        @(posedge clk_i) disable iff (rst_i) !(bus.imem_rvalid_i && (pcq_cnt == '0))
    );

endmodule
